// File: rtl/l2_noc2_arb.sv
// Message-granular arbiter sharing one NoC2 output between pipe1 and pipe2.
// Optional macro L2_NOC2_ARB_PIPE2_PRIO_EN: pipe2 wins idle contention, rr held at 0.
// state | meaning
// IDLE  | next accepted flit is a header; arbitrate between requesters
// LOCK  | multi-flit message in progress; only arb_owner is served
module l2_noc2_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe1_valid,
    input  logic [63:0] pipe1_data,
    output logic        pipe1_ready,
    input  logic        pipe2_valid,
    input  logic [63:0] pipe2_data,
    output logic        pipe2_ready,
    output logic        noc2_valid_out,
    output logic [63:0] noc2_data_out,
    input  logic        noc2_ready_out,
    output logic        arb_busy,
    output logic        arb_owner
);

    typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_rem, w_rem_nxt;
    logic        r_rr, w_rr_nxt;
    logic        r_owner, w_owner_nxt;
    logic        r_pend, w_pend_nxt;
    logic        r_pend_sel, w_pend_sel_nxt;

    logic        w_sel;
    logic        w_sel_valid;
    logic [63:0] w_sel_data;
    logic        w_hs;
    logic [7:0]  w_len;
    logic        w_pend_valid;

    // A header stalled by downstream keeps its grant while its requester holds valid.
    assign w_pend_valid = r_pend_sel ? pipe2_valid : pipe1_valid;

    always_comb begin
        w_sel = r_owner;
        if (r_state == S_IDLE) begin
            if (r_pend && w_pend_valid) begin
                w_sel = r_pend_sel;
            end else if (pipe1_valid && pipe2_valid) begin
`ifdef L2_NOC2_ARB_PIPE2_PRIO_EN
                w_sel = 1'b1;
`else
                w_sel = r_rr;
`endif
            end else if (pipe2_valid) begin
                w_sel = 1'b1;
            end else begin
                w_sel = 1'b0;
            end
        end
    end

    assign w_sel_valid    = w_sel ? pipe2_valid : pipe1_valid;
    assign w_sel_data     = w_sel ? pipe2_data  : pipe1_data;
    assign w_len          = w_sel_data[29:22];

    assign noc2_valid_out = rst_n & w_sel_valid;
    assign noc2_data_out  = noc2_valid_out ? w_sel_data : 64'h0;
    assign pipe1_ready    = rst_n & ~w_sel & noc2_ready_out;
    assign pipe2_ready    = rst_n &  w_sel & noc2_ready_out;
    assign w_hs           = noc2_valid_out & noc2_ready_out;

    assign arb_busy       = (r_state == S_LOCK);
    assign arb_owner      = r_owner;

    always_comb begin
        w_state_nxt    = r_state;
        w_rem_nxt      = r_rem;
        w_rr_nxt       = r_rr;
        w_owner_nxt    = r_owner;
        w_pend_nxt     = 1'b0;
        w_pend_sel_nxt = r_pend_sel;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    w_owner_nxt = w_sel;
`ifdef L2_NOC2_ARB_PIPE2_PRIO_EN
                    w_rr_nxt    = 1'b0;
`else
                    w_rr_nxt    = ~w_sel;
`endif
                    if (w_len != 8'd0) begin
                        w_state_nxt = S_LOCK;
                        w_rem_nxt   = w_len;
                    end
                end else if (w_sel_valid) begin
                    w_pend_nxt     = 1'b1;
                    w_pend_sel_nxt = w_sel;
                end
            end
            S_LOCK: begin
                if (w_hs) begin
                    if (r_rem == 8'd1) begin
                        w_state_nxt = S_IDLE;
                        w_rem_nxt   = 8'd0;
                    end else begin
                        w_rem_nxt   = r_rem - 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_rem_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rem      <= 8'd0;
            r_rr       <= 1'b0;
            r_owner    <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_sel <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rem      <= w_rem_nxt;
            r_rr       <= w_rr_nxt;
            r_owner    <= w_owner_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_sel <= w_pend_sel_nxt;
        end
    end

endmodule

// File: tb/tb_l2_noc2_arb.sv
// Directed bench for l2_noc2_arb; output flits are scoreboarded in expected order.
module tb_l2_noc2_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe1_valid, pipe2_valid;
    logic [63:0] pipe1_data, pipe2_data;
    logic        pipe1_ready, pipe2_ready;
    logic        noc2_valid_out;
    logic [63:0] noc2_data_out;
    logic        noc2_ready_out;
    logic        arb_busy, arb_owner;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_hs    = 0;
    logic [63:0] sb[$];

    l2_noc2_arb dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pipe1_valid    (pipe1_valid),
        .pipe1_data     (pipe1_data),
        .pipe1_ready    (pipe1_ready),
        .pipe2_valid    (pipe2_valid),
        .pipe2_data     (pipe2_data),
        .pipe2_ready    (pipe2_ready),
        .noc2_valid_out (noc2_valid_out),
        .noc2_data_out  (noc2_data_out),
        .noc2_ready_out (noc2_ready_out),
        .arb_busy       (arb_busy),
        .arb_owner      (arb_owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Port tag in the top byte, sequence number, payload length in [29:22].
    function automatic logic [63:0] mk(input int port, input int idx, input int len);
        logic [7:0]  p;
        logic [23:0] s;
        logic [7:0]  l;
        logic [21:0] t;
        p  = 8'(port + 1);
        s  = 24'(idx);
        l  = 8'(len);
        t  = 22'(idx);
        mk = {p, s, 2'b00, l, t};
    endfunction

    task automatic drv(input logic v1, input logic [63:0] d1,
                       input logic v2, input logic [63:0] d2, input logic rdy);
        pipe1_valid    = v1;
        pipe1_data     = d1;
        pipe2_valid    = v2;
        pipe2_data     = d2;
        noc2_ready_out = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && noc2_valid_out && noc2_ready_out) begin
            n_hs++;
            if (sb.size() == 0) chk("sb_underflow", noc2_data_out, 64'h0);
            else                chk("sb_data", noc2_data_out, sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] f1[8];
        logic [63:0] f2[8];
        logic        w[7];
        logic        b[7];
        logic        exp_rr;
        logic        a1, a2;
        int          i1, i2, h0;

        // reset: readies and valid forced low even with live requests
        rst_n = 1'b0;
        drv(1'b1, mk(0, 99, 0), 1'b1, mk(1, 99, 0), 1'b1);
        #3;
        chk("rst_p1_ready", pipe1_ready, 0);
        chk("rst_p2_ready", pipe2_ready, 0);
        chk("rst_valid", noc2_valid_out, 0);
        chk("rst_busy", arb_busy, 0);
        chk("rst_owner", arb_owner, 0);
        tick(); tick();
        rst_n = 1'b1;
        drv(1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        #3;
        chk("idle_valid", noc2_valid_out, 0);
        chk("idle_data", noc2_data_out, 64'h0);
        tick();

        // contention: pipe1 L=2 message vs pipe2 single-flit headers
        for (int k = 0; k < 8; k++) begin
            f1[k] = (k == 0) ? mk(0, 0, 2) : mk(0, k, 0);
            f2[k] = mk(1, k, 0);
        end
`ifdef L2_NOC2_ARB_PIPE2_PRIO_EN
        for (int k = 0; k < 7; k++) begin w[k] = 1'b1; b[k] = 1'b0; end
        exp_rr = 1'b0;
`else
        w = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        b = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_rr = 1'b1;
`endif
        i1 = 0; i2 = 0;
        for (int c = 0; c < 7; c++) begin
            drv(1'b1, f1[i1], 1'b1, f2[i2], 1'b1);
            sb.push_back(w[c] ? f2[i2] : f1[i1]);
            #3;
            chk($sformatf("arb_p1_ready_c%0d", c), pipe1_ready, !w[c]);
            chk($sformatf("arb_p2_ready_c%0d", c), pipe2_ready, w[c]);
            chk($sformatf("arb_busy_c%0d", c), arb_busy, b[c]);
            a1 = pipe1_ready;
            a2 = pipe2_ready;
            tick();
            if (a1) i1++;
            if (a2) i2++;
        end
        drv(1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        #3;
        chk("arb_rr_end", dut.r_rr, exp_rr);
        tick();

        // owner drops valid mid-message while pipe2 requests
        drv(1'b1, mk(0, 10, 3), 1'b0, 64'h0, 1'b1);
        sb.push_back(mk(0, 10, 3));
        #3; tick();
        drv(1'b1, mk(0, 11, 0), 1'b1, mk(1, 20, 0), 1'b1);
        sb.push_back(mk(0, 11, 0));
        #3; tick();
        for (int c = 0; c < 4; c++) begin
            drv(1'b0, mk(0, 12, 0), 1'b1, mk(1, 20, 0), 1'b1);
            #3;
            chk("gap_valid", noc2_valid_out, 0);
            chk("gap_data", noc2_data_out, 64'h0);
            chk("gap_owner", arb_owner, 0);
            chk("gap_rem", dut.r_rem, 2);
            chk("gap_busy", arb_busy, 1);
            chk("gap_p2_ready", pipe2_ready, 0);
            tick();
        end
        drv(1'b1, mk(0, 12, 0), 1'b1, mk(1, 20, 0), 1'b1);
        sb.push_back(mk(0, 12, 0));
        #3;
        chk("resume_busy", arb_busy, 1);
        tick();
        drv(1'b1, mk(0, 13, 0), 1'b1, mk(1, 20, 0), 1'b1);
        sb.push_back(mk(0, 13, 0));
        #3;
        chk("resume_rem_last", dut.r_rem, 1);
        tick();
        drv(1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        #3;
        chk("resume_done_busy", arb_busy, 0);
        chk("resume_done_rem", dut.r_rem, 0);
        tick();

        // downstream stall with pipe2 header pending; pipe1 joins mid-stall
        for (int c = 0; c < 5; c++) begin
            drv(c >= 2, mk(0, 40, 0), 1'b1, mk(1, 30, 1), 1'b0);
            #3;
            chk("stall_data", noc2_data_out, mk(1, 30, 1));
            chk("stall_p1_ready", pipe1_ready, 0);
            chk("stall_p2_ready", pipe2_ready, 0);
            chk("stall_busy", arb_busy, 0);
            tick();
        end
        drv(1'b1, mk(0, 40, 0), 1'b1, mk(1, 30, 1), 1'b1);
        sb.push_back(mk(1, 30, 1));
        #3;
        chk("release_p2_ready", pipe2_ready, 1);
        chk("release_p1_ready", pipe1_ready, 0);
        tick();
        drv(1'b1, mk(0, 40, 0), 1'b1, mk(1, 31, 0), 1'b1);
        sb.push_back(mk(1, 31, 0));
        #3;
        chk("release_busy", arb_busy, 1);
        chk("release_p1_blocked", pipe1_ready, 0);
        tick();
        drv(1'b1, mk(0, 40, 0), 1'b0, 64'h0, 1'b1);
        sb.push_back(mk(0, 40, 0));
        #3;
        chk("after_stall_p1_ready", pipe1_ready, 1);
        tick();
        drv(1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        #3;
        chk("after_stall_busy", arb_busy, 0);
        tick();

        // reset pulse at flit 3 of an L=255 message
        drv(1'b1, mk(0, 50, 255), 1'b0, 64'h0, 1'b1);
        sb.push_back(mk(0, 50, 255));
        #3; tick();
        drv(1'b1, mk(0, 51, 0), 1'b0, 64'h0, 1'b1);
        sb.push_back(mk(0, 51, 0));
        #3; tick();
        drv(1'b1, mk(0, 52, 7), 1'b0, 64'h0, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", arb_busy, 0);
        chk("mrst_rem", dut.r_rem, 0);
        chk("mrst_rr", dut.r_rr, 0);
        chk("mrst_p1_ready", pipe1_ready, 0);
        chk("mrst_p2_ready", pipe2_ready, 0);
        chk("mrst_valid", noc2_valid_out, 0);
        #1;
        drv(1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        rst_n = 1'b1;
        tick();
        drv(1'b1, mk(0, 60, 1), 1'b0, 64'h0, 1'b1);
        sb.push_back(mk(0, 60, 1));
        #3; tick();
        drv(1'b1, mk(0, 61, 0), 1'b0, 64'h0, 1'b1);
        sb.push_back(mk(0, 61, 0));
        #3;
        chk("post_rst_hdr_busy", arb_busy, 1);
        chk("post_rst_hdr_rem", dut.r_rem, 1);
        tick();
        drv(1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        #3;
        chk("post_rst_done_busy", arb_busy, 0);
        tick();

        // L=255: exactly 256 flits under lock
        h0 = n_hs;
        drv(1'b1, mk(0, 100, 255), 1'b0, 64'h0, 1'b1);
        sb.push_back(mk(0, 100, 255));
        #3; tick();
        for (int k = 1; k < 256; k++) begin
            drv(1'b1, mk(0, 100 + k, 0), 1'b0, 64'h0, 1'b1);
            sb.push_back(mk(0, 100 + k, 0));
            #3;
            chk("max_busy", arb_busy, 1);
            if (k == 255) chk("max_rem_last", dut.r_rem, 1);
            tick();
        end
        drv(1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        #3;
        chk("max_done_busy", arb_busy, 0);
        chk("max_done_rem", dut.r_rem, 0);
        chk("max_hs_count", n_hs - h0, 256);
        tick();

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_noc2_arb.md
L2_NOC2_ARB -- requirements
Module: l2_noc2_arb

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-002 SHALL provide these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- pipe1_valid  in  1  pipe1 NoC2 flit valid
- pipe1_data  in  64  pipe1 NoC2 flit
- pipe1_ready  out  1  pipe1 flit accepted this cycle
- pipe2_valid  in  1  pipe2 NoC2 flit valid
- pipe2_data  in  64  pipe2 NoC2 flit
- pipe2_ready  out  1  pipe2 flit accepted this cycle
- noc2_valid_out  out  1  NoC2 output flit valid
- noc2_data_out  out  64  NoC2 output flit
- noc2_ready_out  in  1  NoC2 downstream ready
- arb_busy  out  1  a multi-flit message is in progress
- arb_owner  out  1  current or last granted port: 0 = pipe1, 1 = pipe2

Function
REQ-003 SHALL share the single NoC2 output between pipe1 and pipe2 at whole-message granularity; flits of two messages never interleave.
REQ-004 SHALL treat the first flit offered while idle as a header; payload length L = header bits [29:22] (0..255); message = 1+L flits.
REQ-005 SHALL implement FSM states IDLE and LOCK, plus an 8-bit remaining-flit counter rem and a 1-bit round-robin pointer rr.
REQ-006 In IDLE, with one requester valid, SHALL select that requester; with both valid, SHALL select port rr; with none valid, noc2_valid_out = 0.
REQ-007 Datapath SHALL be zero-latency: noc2_valid_out = selected valid; noc2_data_out = selected data; selected ready = noc2_ready_out; non-selected ready = 0.
REQ-008 noc2_data_out SHALL be 64'h0 whenever noc2_valid_out = 0.
REQ-009 Header handshake (valid & noc2_ready_out) in IDLE with L > 0: go to LOCK, rem = L, arb_owner = selected port, rr = ~selected.
REQ-010 Header handshake in IDLE with L = 0: stay IDLE; rr = ~selected; arb_owner = selected.
REQ-011 In LOCK, SHALL select only arb_owner and ignore the other port's valid.
REQ-012 In LOCK, each handshake SHALL decrement rem; the handshake with rem = 1 SHALL return to IDLE with rem = 0.
REQ-013 Owner valid deasserting mid-message SHALL hold LOCK, rem and owner, with noc2_valid_out = 0; no switch.
REQ-014 noc2_ready_out low SHALL stall with no state change; the selection made in IDLE SHALL NOT change while its header is stalled if that requester stays valid.
REQ-015 arb_busy SHALL equal (state == LOCK).
REQ-016 L = 255 SHALL lock for exactly 256 flits; rem SHALL never wrap.

Reset
REQ-017 rst_n low SHALL asynchronously force state = IDLE, rem = 0, rr = 0, arb_owner = 0, arb_busy = 0, noc2_valid_out = 0, pipe1_ready = 0, pipe2_ready = 0.
REQ-018 Reset mid-message SHALL abandon the message; the first flit offered after reset is a header.

Configuration
REQ-019 Macro L2_NOC2_ARB_PIPE2_PRIO_EN:
- defined: in IDLE, pipe2 always wins when both valid; rr is unused and held at 0.
- undefined: round-robin per REQ-006 and REQ-009.
- all other behaviour identical.

Verification
REQ-020 Bench SHALL cover these directed scenarios:
- Both valid; pipe1 header L=2; pipe2 header L=0; ready=1 -> output pipe1 H,P,P, then pipe2 H; pipe2_ready=0 during cycles 0-2; arb_busy=1 during cycles 1-2.
- Continuing from the previous scenario with both valid and L=0 -> grants alternate pipe1, pipe2, pipe1 (macro undefined); with macro defined -> pipe2 every cycle.
- pipe1 header L=3; pipe1_valid drops after flit 2 for 4 cycles while pipe2 valid -> noc2_valid_out=0, owner=0, rem=2 held; then pipe1 resumes and completes.
- noc2_ready_out=0 for 5 cycles with pipe2 header L=1 pending -> no readies, state IDLE, data stable; release -> 2 flits out.
- rst_n pulsed low at flit 3 of an L=255 message -> immediate IDLE, rem=0, rr=0, all readies 0; next flit treated as header.
- L=255 message -> exactly 256 handshakes, then arb_busy=0.
